// File: rtl/detector_sentido_pkg.sv
// Shared definitions for the crossing-direction detector: FSM state codes
// and the default debounce length.
package detector_sentido_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int DEB_W_DEF      = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6,
    CLR  = 3'd7
  } state_t;

endpackage

// File: rtl/detector_sentido_filtro_rebote.sv
// Two-flop synchroniser followed by a debounce counter; the filtered level
// only follows the synced level after DEB_CYCLES consecutive disagreeing cycles.
module filtro_rebote
  import detector_sentido_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEB_W      = DEB_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [DEB_W-1:0] cnt;

  // stage p0/p1: metastability guard for the asynchronous sensor
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // debounce stage: counter runs only while synced and filtered disagree
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync_p1 == filt) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      filt <= sync_p1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/detector_sentido.sv
// Direction detector: filters both barrier sensors and tracks the crossing
// order, pulsing z1 on a full entry, z2 on a full exit, abort on illegal jumps.
module detector_sentido
  import detector_sentido_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEB_W      = DEB_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic z1,
  output logic z2,
  output logic abort,
  output logic busy
);

  logic       fa;
  logic       fb;
  logic [1:0] pair;
  state_t     state;
  state_t     next;
  logic       z1_n;
  logic       z2_n;
  logic       abort_n;

  filtro_rebote #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_fa (
    .clk   (clk),
    .reset (reset),
    .raw   (a),
    .filt  (fa)
  );

  filtro_rebote #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_fb (
    .clk   (clk),
    .reset (reset),
    .raw   (b),
    .filt  (fb)
  );

  assign pair = {fa, fb};

  // Each state handles exactly one outcome per input pair, so at most one
  // pulse request can be raised per cycle.
  always_comb begin
    next    = state;
    z1_n    = 1'b0;
    z2_n    = 1'b0;
    abort_n = 1'b0;
    case (state)
      IDLE: begin
        case (pair)
          2'b10:   next = E1;
          2'b01:   next = X1;
          2'b11:   begin next = CLR; abort_n = 1'b1; end
          default: next = IDLE;
        endcase
      end
      E1: begin
        case (pair)
          2'b11:   next = E2;
          2'b00:   next = IDLE;
          2'b01:   begin next = CLR; abort_n = 1'b1; end
          default: next = E1;
        endcase
      end
      E2: begin
        case (pair)
          2'b01:   next = E3;
          2'b10:   next = E1;
          2'b00:   begin next = CLR; abort_n = 1'b1; end
          default: next = E2;
        endcase
      end
      E3: begin
        case (pair)
          2'b00:   begin next = IDLE; z1_n = 1'b1; end
          2'b11:   next = E2;
          2'b10:   begin next = CLR; abort_n = 1'b1; end
          default: next = E3;
        endcase
      end
      X1: begin
        case (pair)
          2'b11:   next = X2;
          2'b00:   next = IDLE;
          2'b10:   begin next = CLR; abort_n = 1'b1; end
          default: next = X1;
        endcase
      end
      X2: begin
        case (pair)
          2'b10:   next = X3;
          2'b01:   next = X1;
          2'b00:   begin next = CLR; abort_n = 1'b1; end
          default: next = X2;
        endcase
      end
      X3: begin
        case (pair)
          2'b00:   begin next = IDLE; z2_n = 1'b1; end
          2'b11:   next = X2;
          2'b01:   begin next = CLR; abort_n = 1'b1; end
          default: next = X3;
        endcase
      end
      CLR: begin
        if (pair == 2'b00) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // output stage: pulses and busy registered from the next-state decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      z1    <= 1'b0;
      z2    <= 1'b0;
      abort <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= next;
      z1    <= z1_n;
      z2    <= z2_n;
      abort <= abort_n;
      busy  <= (next != IDLE);
    end
  end

endmodule

// File: doc/detector_sentido.md
Name: detector_sentido

Overview:
- Upstream stage of the occupancy counter. Watches two raw photo-barrier sensors, a (outer) and b (inner), placed in sequence across the access lane.
- Synchronises and debounces both inputs, then tracks the crossing order with an FSM.
- Emits one-cycle pulses: z1 for a complete entry, z2 for a complete exit.
- Guarantees z1 and z2 are never high together, so the counter never sees {z1,z2}=11.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles needed before a filtered sensor level changes (legal range 1..255).
- DEB_W, 8: width of the debounce counter; must hold DEB_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- a  input  1  raw outer sensor, 1 = beam blocked; asynchronous to clk.
- b  input  1  raw inner sensor, 1 = beam blocked; asynchronous to clk.
- z1  output  1  registered entry pulse, exactly one cycle wide.
- z2  output  1  registered exit pulse, exactly one cycle wide.
- abort  output  1  registered one-cycle pulse: illegal sensor jump detected.
- busy  output  1  registered; 1 while a crossing is in progress (state not IDLE).

Behaviour:
- Reset (async, active-high):
  - synchroniser flops = 0, filtered levels fa = fb = 0, debounce counters = 0;
  - state = IDLE; z1 = z2 = abort = busy = 0.
- Synchroniser: two flops per input. The FSM never uses a or b directly.
- Debounce (per input):
  - if synced level == filtered level: counter clears to 0;
  - otherwise the counter increments; when it reaches DEB_CYCLES-1, the filtered level takes the synced value and the counter clears;
  - a glitch shorter than DEB_CYCLES cycles never reaches the FSM.
- Latency, raw edge to filtered edge: 2 + DEB_CYCLES cycles.
- FSM input is the filtered pair {fa,fb}. States:
  - IDLE: 10 -> E1; 01 -> X1; 11 -> CLR with abort pulse; 00 stays.
  - E1 (a only): 11 -> E2; 00 -> IDLE (walked back, no pulse); 01 -> CLR with abort; 10 stays.
  - E2 (both): 01 -> E3; 10 -> E1; 00 -> CLR with abort; 11 stays.
  - E3 (b only): 00 -> IDLE with z1 pulse; 11 -> E2; 10 -> CLR with abort; 01 stays.
  - X1 / X2 / X3: mirror of E1 / E2 / E3 with a and b swapped; leaving X3 on 00 gives a z2 pulse.
  - CLR: waits for 00, then -> IDLE with no pulse. Any other value stays.
- Pulse timing:
  - z1, z2 and abort are registered; each goes high in the cycle after the transition edge and lasts exactly one cycle;
  - back-to-back crossings still need at least DEB_CYCLES cycles of 00 between them, so pulses are never adjacent.
- busy = 1 in every state except IDLE, registered from the next-state value.
- Simultaneous events: at most one of z1, z2, abort is high in any cycle, by construction.
- State encoding: 3 bits. Unused codes fall to IDLE with no pulse.
- Reset mid-crossing: the FSM returns to IDLE and no pulse is produced. A crossing still partly seen after reset resolves through the normal transitions above.

Decomposition:
- Shared package holds:
  - the state localparams IDLE, E1, E2, E3, X1, X2, X3, CLR;
  - the default DEB_CYCLES.
- One sub-module is natural: filtro_rebote (2-flop synchroniser plus debounce counter, parameterised by DEB_CYCLES and DEB_W). Instantiate it twice, once for a and once for b.

Test Plan:
- Entry: with DEB_CYCLES=4, drive a=1 for 20 cycles, then a=b=1 for 20, then b only for 20, then 00. Exactly one z1 pulse appears 2+4+1 = 7 cycles after the final 00 edge; z2 and abort stay 0; busy drops in the same cycle as the z1 pulse.
- Exit: mirror sequence (b, ab, a, 00). Exactly one z2 pulse at the same latency; z1 = 0.
- Glitch rejection: a 3-cycle pulse on a while idle gives no state change and busy stays 0. A 4-cycle pulse gives E1 then IDLE with no z1 or z2.
- Walk-back: a, ab, a, 00. The FSM goes E1 -> E2 -> E1 -> IDLE; no pulses.
- Illegal jump: from idle, a and b rise in the same cycle. abort pulses once and the FSM holds in CLR until 00, then returns to IDLE. No z1 or z2.
- Reset mid-operation: assert reset while in E3. All outputs are 0 immediately (asynchronously). After release with inputs 00, no z1 is emitted.
